adia_pclk_gen: RTL and testbench

- Upstream power-clock generator for the two-stage adiabatic gate cells in the adder. Those cells have a first stage on clkpos/clkneg and an output stage on clkpos2/clkneg2.
- Produces two split-level trapezoidal power-clock pairs as stepwise level codes, plus 1-bit digital rail abstractions for the switch-level gate models.
- Phase 2 lags phase 1 by exactly one quarter period.
- Includes a run/stop handshake so rails only start or stop at a period boundary, when all rails sit at mid-level.

---
 rtl/adia_pclk_if.sv | 30 +++
 rtl/adia_pclk_gen.sv | 110 +++++++++++
 tb/tb_adia_pclk_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/adia_pclk_if.sv
// Power-clock bus between adia_pclk_gen (master) and the two-stage adiabatic gate cells (slave).
interface adia_pclk_if #(
  parameter int STEPS = 4
);
  localparam int LW = $clog2(2*STEPS+1);

  logic          run_req;
  logic          running;
  logic [LW-1:0] clkpos_lvl;
  logic [LW-1:0] clkneg_lvl;
  logic [LW-1:0] clkpos2_lvl;
  logic [LW-1:0] clkneg2_lvl;
  logic          clkpos;
  logic          clkneg;
  logic          clkpos2;
  logic          clkneg2;
  logic          sample;

  modport master (
    input  run_req,
    output running, clkpos_lvl, clkneg_lvl, clkpos2_lvl, clkneg2_lvl,
           clkpos, clkneg, clkpos2, clkneg2, sample
  );

  modport slave (
    output run_req,
    input  running, clkpos_lvl, clkneg_lvl, clkpos2_lvl, clkneg2_lvl,
           clkpos, clkneg, clkpos2, clkneg2, sample
  );
endinterface

// File: rtl/adia_pclk_gen.sv
// Two-phase trapezoidal power-clock generator with run/stop at period boundaries.
// Optional ADIA_PCLK_CYCLE_CNT_EN adds a saturating 16-bit period counter port.
module adia_pclk_gen #(
  parameter int STEPS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ADIA_PCLK_CYCLE_CNT_EN
  output logic [15:0] period_cnt,
`endif
  adia_pclk_if.master bus
);
  localparam int LW = $clog2(2*STEPS+1);
  localparam int RW = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

  state_e        state_q, state_d;
  logic [1:0]    q_q, q_d;
  logic [RW-1:0] r_q, r_d;
  logic [LW-1:0] k1_q, k1_d, k2_q, k2_d;
  logic          last_r, wrap;

  // cnt is held split as quarter q and in-quarter index r, so no divider is needed
  function automatic logic [LW-1:0] ramp(input logic [1:0] q, input logic [RW-1:0] r);
    case (q)
      2'd0:    return LW'(r) + LW'(1);
      2'd1:    return LW'(STEPS);
      2'd2:    return LW'(STEPS-1) - LW'(r);
      default: return '0;
    endcase
  endfunction

  assign last_r = (r_q == RW'(STEPS-1));
  assign wrap   = last_r && (q_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.run_req) state_d = RUN;
      RUN:      if (!bus.run_req) state_d = STOPPING;
      STOPPING: if (bus.run_req) state_d = RUN;
                else if (wrap)   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // k indices are registered from next cnt so they line up with cnt; phase 2 runs one quarter behind
  always_comb begin
    q_d = q_q;
    r_d = r_q;
    if (state_d == IDLE || state_q == IDLE) begin
      q_d = '0;
      r_d = '0;
    end else if (last_r) begin
      r_d = '0;
      q_d = q_q + 2'd1;
    end else begin
      r_d = r_q + RW'(1);
    end
    k1_d = (state_d == IDLE) ? '0 : ramp(q_d, r_d);
    k2_d = (state_d == IDLE) ? '0 : ramp(q_d + 2'd3, r_d);
  end

  always_comb begin
    bus.running     = (state_q != IDLE);
    bus.sample      = (state_q != IDLE) && (q_q == 2'd2) && last_r;
    bus.clkpos_lvl  = LW'(STEPS) + k1_q;
    bus.clkneg_lvl  = LW'(STEPS) - k1_q;
    bus.clkpos2_lvl = LW'(STEPS) + k2_q;
    bus.clkneg2_lvl = LW'(STEPS) - k2_q;
    bus.clkpos      = (k1_q == LW'(STEPS));
    bus.clkneg      = (k1_q != LW'(STEPS));
    bus.clkpos2     = (k2_q == LW'(STEPS));
    bus.clkneg2     = (k2_q != LW'(STEPS));
  end

`ifdef ADIA_PCLK_CYCLE_CNT_EN
  logic [15:0] period_cnt_q, period_cnt_d;

  always_comb begin
    period_cnt_d = period_cnt_q;
    if (state_q != IDLE && wrap && period_cnt_q != 16'hFFFF)
      period_cnt_d = period_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) period_cnt_q <= '0;
    else        period_cnt_q <= period_cnt_d;
  end

  assign period_cnt = period_cnt_q;
`endif
endmodule

// File: tb/tb_adia_pclk_gen.sv
// Directed + randomized bench for adia_pclk_gen against a cycle-level model built from the ramp rules.
module tb_adia_pclk_gen;
  localparam int S = 4;
  localparam int P = 4*S;

  logic clk;
  logic rst_n;
`ifdef ADIA_PCLK_CYCLE_CNT_EN
  logic [15:0] period_cnt;
`endif

  adia_pclk_if #(.STEPS(S)) bus ();

  adia_pclk_gen #(.STEPS(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ADIA_PCLK_CYCLE_CNT_EN
    .period_cnt (period_cnt),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass  = 0;
  int ntotal = 0;

  // reference model: active flag, stop-pending flag, position within the period, period count
  bit m_on   = 0;
  bit m_stop = 0;
  int m_cnt  = 0;
  int m_per  = 0;

  int tbl [16] = '{5,6,7,8, 8,8,8,8, 7,6,5,4, 4,4,4,4};

  function automatic int kf(input int c);
    int q = c / S;
    int r = c % S;
    case (q)
      0:       return r + 1;
      1:       return S;
      2:       return S - 1 - r;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    int k1, k2;
    k1 = m_on ? kf(m_cnt) : 0;
    k2 = m_on ? kf((m_cnt + 3*S) % P) : 0;
    chk("running",     bus.running,     m_on);
    chk("clkpos_lvl",  bus.clkpos_lvl,  S + k1);
    chk("clkneg_lvl",  bus.clkneg_lvl,  S - k1);
    chk("clkpos2_lvl", bus.clkpos2_lvl, S + k2);
    chk("clkneg2_lvl", bus.clkneg2_lvl, S - k2);
    chk("clkpos",      bus.clkpos,      k1 == S);
    chk("clkneg",      bus.clkneg,      k1 != S);
    chk("clkpos2",     bus.clkpos2,     k2 == S);
    chk("clkneg2",     bus.clkneg2,     k2 != S);
    chk("sample",      bus.sample,      m_on && m_cnt == 3*S-1);
`ifdef ADIA_PCLK_CYCLE_CNT_EN
    chk("period_cnt",  period_cnt,      m_per);
`endif
  endtask

  task automatic model_reset();
    m_on = 0; m_stop = 0; m_cnt = 0; m_per = 0;
  endtask

  task automatic tick(input bit r);
    bus.run_req = r;
    @(posedge clk);
    if (!m_on) begin
      if (r) begin m_on = 1; m_stop = 0; m_cnt = 0; end
    end else begin
      if (m_cnt == P-1 && m_per < 65535) m_per++;
      if (m_stop && !r && m_cnt == P-1) begin
        m_on = 0; m_stop = 0; m_cnt = 0;
      end else begin
        m_stop = !r;
        m_cnt  = (m_cnt + 1) % P;
      end
    end
    #1;
    check_all();
  endtask

  task automatic run_until(input int target);
    for (int n = 0; n < 2*P && !(m_on && m_cnt == target); n++) tick(1'b1);
  endtask

  initial begin
    int n;
    bit r;
    rst_n = 1'b0;
    bus.run_req = 1'b0;
    model_reset();
    #3;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // idle: nothing moves without run_req
    repeat (20) tick(1'b0);

    // one full period against the literal level table
    for (int i = 0; i < 16; i++) begin
      tick(1'b1);
      chk("tbl_clkpos",  bus.clkpos_lvl,  tbl[i]);
      chk("tbl_clkpos2", bus.clkpos2_lvl, (i >= 4) ? tbl[i-4] : 4);
      chk("tbl_clkneg",  bus.clkneg_lvl,  8 - tbl[i]);
      chk("tbl_sample",  bus.sample,      i == 11);
    end

    // stop requested mid-period: the period completes, then idle
    run_until(5);
    tick(1'b0);
    n = 1;
    while (bus.running && n < 40) begin tick(1'b0); n++; end
    chk("stop_cycles", n, 11);
    repeat (3) tick(1'b0);

    // stop cancelled before the wrap
    run_until(5);
    repeat (4) tick(1'b0);
    repeat (8) tick(1'b1);
    chk("cancel_running", bus.running, 1);

    // async reset mid-ramp, then clean restart
    run_until(6);
    chk("pre_reset_lvl", bus.clkpos_lvl, 8);
    #2;
    rst_n = 1'b0;
    bus.run_req = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    tick(1'b1);
    chk("restart_lvl", bus.clkpos_lvl, 5);

`ifdef ADIA_PCLK_CYCLE_CNT_EN
    @(negedge clk) rst_n = 1'b0;
    bus.run_req = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (47) tick(1'b1);
    repeat (6) tick(1'b0);
    chk("period_cnt_3", period_cnt, 3);
`endif

    // randomized run_req with sticky levels
    r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) r = ~r;
      tick(r);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
